// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and key map for the 4x4 keypad scanner
// Contents: FSM state enum, snapshot class enum, 16-entry key map
// (index = 4*row + col), key lookup helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD
    } state_t;

    typedef enum logic [1:0] {
        SNAP_NONE,
        SNAP_SINGLE,
        SNAP_MULTI
    } snap_class_t;

    // Nibble i is the code for snapshot bit i (row = i/4, col = i%4).
    // Rows read 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
    localparam logic [63:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_of(input int unsigned idx);
        return KEY_MAP[4*idx +: 4];
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key/entry output bundle
// Signals: col_in (4, active-low columns), clear (entry clear),
// row_out (4, active-low rows), key_code (4), key_valid (pulse),
// binary_value (8, {older, newer}), value_valid (pulse).
// master: the scanner side; slave: keypad/processor side.
interface keypad_scanner_if;
    logic [3:0] col_in;
    logic       clear;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic [7:0] binary_value;
    logic       value_valid;

    modport master (
        input  col_in, clear,
        output row_out, key_code, key_valid, binary_value, value_valid
    );

    modport slave (
        output col_in, clear,
        input  row_out, key_code, key_valid, binary_value, value_valid
    );
endinterface

// File: rtl/keypad_code_decoder.sv
// rtl/keypad_code_decoder.sv - classifies a full-scan snapshot and maps it to a key code
// Ports: snapshot (16, one bit per key, 1 = pressed) in;
// snap_class (NONE/SINGLE/MULTI) out; code (4, valid for SINGLE) out.
module keypad_code_decoder
    import keypad_pkg::*;
(
    input  logic [15:0] snapshot,
    output snap_class_t snap_class,
    output logic [3:0]  code
);

    logic [4:0] ones;

    always_comb begin
        ones = '0;
        code = '0;
        for (int i = 0; i < 16; i++) begin
            if (snapshot[i]) begin
                ones = ones + 5'd1;
                code = key_of(i);
            end
        end
        if (ones == 5'd0) begin
            snap_class = SNAP_NONE;
        end else if (ones == 5'd1) begin
            snap_class = SNAP_SINGLE;
        end else begin
            snap_class = SNAP_MULTI;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner, debouncer and two-digit entry register
// Ports: clk, reset (async active-low), bus (keypad_scanner_if.master):
// col_in/clear in; row_out, key_code, key_valid, binary_value, value_valid out.
// Parameters: SCAN_DIV (cycles per row, >= 4), DEBOUNCE_SCANS (stable scans
// needed to accept a press and to accept a release).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 131072,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  bus
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

    // Column synchronizer; idles high (no key) out of reset.
    logic [3:0] col_meta;
    logic [3:0] col_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= bus.col_in;
            col_sync <= col_meta;
        end
    end

    // Row scanner. Columns are sampled in the last cycle of a row slot so
    // the driven row has had the whole slot to settle through the synchronizer.
    logic [DIV_W-1:0] div;
    logic [1:0]       row_idx;
    logic [15:0]      snapshot;
    logic [15:0]      snap_full;
    logic             sample;
    logic             scan_done;

    assign sample    = (div == DIV_LAST);
    assign scan_done = sample && (row_idx == 2'd3);

    // Snapshot including the row being sampled this cycle, so the decoder
    // sees the completed scan on the row-3 sample cycle itself.
    always_comb begin
        snap_full = snapshot;
        snap_full[4*row_idx +: 4] = ~col_sync;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div      <= '0;
            row_idx  <= 2'd0;
            snapshot <= '0;
        end else if (sample) begin
            div      <= '0;
            row_idx  <= row_idx + 2'd1;
            snapshot <= snap_full;
        end else begin
            div      <= div + DIV_W'(1);
        end
    end

    assign bus.row_out = ~(4'b0001 << row_idx);

    snap_class_t snap_class;
    logic [3:0]  snap_code;

    keypad_code_decoder u_decoder (
        .snapshot   (snap_full),
        .snap_class (snap_class),
        .code       (snap_code)
    );

    // Debounce FSM, advanced only on scan completion.
    state_t           state, state_nx;
    logic [3:0]       cand, cand_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] rel_cnt, rel_nx;
    logic             accept;
    logic [3:0]       accept_code;
    logic [3:0]       key_code_q;
    logic             key_valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cand        <= '0;
            cnt         <= '0;
            rel_cnt     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state       <= state_nx;
            cand        <= cand_nx;
            cnt         <= cnt_nx;
            rel_cnt     <= rel_nx;
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= accept_code;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        cand_nx     = cand;
        cnt_nx      = cnt;
        rel_nx      = rel_cnt;
        accept      = 1'b0;
        accept_code = cand;
        if (scan_done) begin
            case (state)
                ST_IDLE: begin
                    if (snap_class == SNAP_SINGLE) begin
                        cand_nx = snap_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept      = 1'b1;
                            accept_code = snap_code;
                            rel_nx      = '0;
                            state_nx    = ST_HELD;
                        end else begin
                            cnt_nx   = CNT_W'(1);
                            state_nx = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if ((snap_class == SNAP_SINGLE) && (snap_code == cand)) begin
                        if (cnt + CNT_W'(1) == CNT_TARGET) begin
                            accept   = 1'b1;
                            cnt_nx   = '0;
                            rel_nx   = '0;
                            state_nx = ST_HELD;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end else begin
                        // A broken run abandons the candidate outright; the
                        // offending snapshot does not start a new one.
                        cnt_nx   = '0;
                        state_nx = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (snap_class == SNAP_NONE) begin
                        if (rel_cnt + CNT_W'(1) == CNT_TARGET) begin
                            rel_nx   = '0;
                            state_nx = ST_IDLE;
                        end else begin
                            rel_nx = rel_cnt + CNT_W'(1);
                        end
                    end else begin
                        rel_nx = '0;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;

    // Entry register: shifts in the accepted key one cycle after key_valid.
    logic [7:0] value_q;
    logic       digit_cnt;
    logic       value_valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q       <= '0;
            digit_cnt     <= 1'b0;
            value_valid_q <= 1'b0;
        end else if (bus.clear) begin
            value_q       <= '0;
            digit_cnt     <= 1'b0;
            value_valid_q <= 1'b0;
        end else if (key_valid_q) begin
            value_q       <= {value_q[3:0], key_code_q};
            digit_cnt     <= ~digit_cnt;
            value_valid_q <= digit_cnt;
        end else begin
            value_valid_q <= 1'b0;
        end
    end

    assign bus.binary_value = value_q;
    assign bus.value_valid  = value_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [15:0] pressed = '0;

    always #5 clk = ~clk;

    keypad_scanner_if bus();

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Passive key matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        bus.col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!bus.row_out[r]) begin
                bus.col_in = bus.col_in & ~pressed[4*r +: 4];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: keypad seen through a 2-cycle delay, one row per SD
    // cycles, a press/release accepted after DB matching whole scans.
    int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
    int k;
    int mr;
    int nbits;
    int mcode;
    int run;
    int rel;
    int cand;
    bit held;
    bit e_digit;
    logic [15:0] p1, p2, m_snap;
    logic [3:0] e_code;
    logic e_kv, e_vv;
    logic [7:0] e_bv;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            k = 0; p1 = '0; p2 = '0; m_snap = '0;
            held = 0; run = 0; rel = 0; cand = 0;
            e_code = '0; e_kv = 0; e_bv = '0; e_vv = 0; e_digit = 0;
        end else begin
            if (bus.clear) begin
                e_bv = '0; e_digit = 0; e_vv = 0;
            end else if (e_kv) begin
                e_bv = {e_bv[3:0], e_code};
                e_vv = e_digit;
                e_digit = !e_digit;
            end else begin
                e_vv = 0;
            end
            e_kv = 0;
            if (k % SD == SD - 1) begin
                mr = (k / SD) % 4;
                m_snap[4*mr +: 4] = p2[4*mr +: 4];
                if (mr == 3) begin
                    nbits = $countones(m_snap);
                    mcode = -1;
                    for (int i = 0; i < 16; i++) if (m_snap[i]) mcode = keymap[i];
                    if (!held) begin
                        if (run > 0) begin
                            if (nbits == 1 && mcode == cand) run++;
                            else run = 0;
                        end else if (nbits == 1) begin
                            cand = mcode;
                            run = 1;
                        end
                        if (run == DB) begin
                            held = 1; rel = 0; run = 0;
                            e_kv = 1; e_code = 4'(cand);
                        end
                    end else begin
                        if (nbits == 0) begin
                            rel++;
                            if (rel == DB) held = 0;
                        end else begin
                            rel = 0;
                        end
                    end
                end
            end
            p2 = p1;
            p1 = pressed;
            k++;
        end
    end

    logic [3:0] e_row;
    always @(negedge clk) begin
        e_row = ~(4'b0001 << ((k / SD) % 4));
        check("row_out", bus.row_out, e_row);
        check("key_valid", bus.key_valid, e_kv);
        check("key_code", bus.key_code, e_code);
        check("binary_value", bus.binary_value, e_bv);
        check("value_valid", bus.value_valid, e_vv);
    end

    int kv_count = 0;
    int vv_count = 0;
    always @(posedge clk) begin
        if (bus.key_valid === 1'b1) kv_count++;
        if (bus.value_valid === 1'b1) vv_count++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_kv(input int limit, output bit seen);
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.key_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
    endtask

    logic [3:0] rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bit seen;
    int c0;
    int c1;

    initial begin
        bus.clear = 1'b0;
        step(3);
        reset = 1'b1;
        step(6);
        reset = 1'b0;
        @(negedge clk);
        check("rst_row_out", bus.row_out, 4'b1110);
        check("rst_key_valid", bus.key_valid, 1'b0);
        check("rst_key_code", bus.key_code, 4'h0);
        check("rst_binary_value", bus.binary_value, 8'h00);
        check("rst_value_valid", bus.value_valid, 1'b0);
        step(2);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("row_seq", bus.row_out, rows[i/4]);
        end

        // Single press of '6' (row 1, col 2).
        step(1);
        c0 = kv_count;
        pressed = 16'(1) << 6;
        wait_kv(52, seen);
        check("press6_seen", 8'(seen), 8'd1);
        check("press6_code", bus.key_code, 4'h6);
        step(64);
        check("press6_pulses", 8'(kv_count - c0), 8'd1);
        pressed = '0;
        step(56);

        // Bounce with a 32-cycle period: successive row-1 samples alternate.
        c0 = kv_count;
        for (int i = 0; i < 8; i++) begin
            pressed = pressed ^ (16'(1) << 6);
            step(16);
        end
        step(56);
        check("bounce_pulses", 8'(kv_count - c0), 8'd0);

        // Two-digit entry: '3' then 'C'.
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        c1 = vv_count;
        pressed = 16'(1) << 2;
        wait_kv(52, seen);
        check("press3_seen", 8'(seen), 8'd1);
        check("press3_code", bus.key_code, 4'h3);
        @(negedge clk);
        check("entry_03", bus.binary_value, 8'h03);
        check("entry_03_vv", bus.value_valid, 1'b0);
        pressed = '0;
        step(56);
        pressed = 16'(1) << 11;
        wait_kv(52, seen);
        check("pressC_seen", 8'(seen), 8'd1);
        check("pressC_code", bus.key_code, 4'hC);
        @(negedge clk);
        check("entry_3C", bus.binary_value, 8'h3C);
        check("entry_3C_vv", bus.value_valid, 1'b1);
        pressed = '0;
        step(56);
        check("vv_pulses", 8'(vv_count - c1), 8'd1);

        // Multi-key: '1' and '5' together, then '5' released.
        c0 = kv_count;
        pressed = (16'(1) << 0) | (16'(1) << 5);
        step(64);
        check("multi_pulses", 8'(kv_count - c0), 8'd0);
        pressed = 16'(1) << 0;
        wait_kv(52, seen);
        check("press1_seen", 8'(seen), 8'd1);
        check("press1_code", bus.key_code, 4'h1);
        pressed = '0;
        step(56);

        // Clear colliding with the second-digit entry update.
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        pressed = 16'(1) << 1;
        wait_kv(52, seen);
        check("press2_seen", 8'(seen), 8'd1);
        pressed = '0;
        step(56);
        c1 = vv_count;
        pressed = 16'(1) << 9;
        wait_kv(52, seen);
        check("press8_seen", 8'(seen), 8'd1);
        bus.clear = 1'b1;
        @(posedge clk);
        #2;
        bus.clear = 1'b0;
        @(negedge clk);
        check("collide_value", bus.binary_value, 8'h00);
        check("collide_vv", bus.value_valid, 1'b0);
        pressed = '0;
        step(56);
        check("collide_vv_pulses", 8'(vv_count - c1), 8'd0);
        pressed = 16'(1) << 8;
        wait_kv(52, seen);
        check("press7_code", bus.key_code, 4'h7);
        @(negedge clk);
        check("entry_07", bus.binary_value, 8'h07);
        pressed = '0;
        step(56);

        // Reset while '9' is held: must debounce again afterwards.
        pressed = 16'(1) << 10;
        wait_kv(52, seen);
        check("press9_seen", 8'(seen), 8'd1);
        step(5);
        reset = 1'b0;
        @(negedge clk);
        check("midpress_rst_code", bus.key_code, 4'h0);
        check("midpress_rst_row", bus.row_out, 4'b1110);
        step(2);
        reset = 1'b1;
        wait_kv(52, seen);
        check("press9_again_seen", 8'(seen), 8'd1);
        check("press9_again_code", bus.key_code, 4'h9);
        pressed = '0;
        step(56);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
